aes_serial_ctrl: RTL
====================

Name: aes_serial_ctrl

Overview:
Host-side sequencer for the two bit-serial AES slaves (encrypt and decrypt wrappers, MOSI/MISO/CS interface).
- Accepts one parallel request: 128-bit block, key and mode.
- Selects one slave and shifts {block,key} into it MSB-first.
- Waits a fixed core latency, then collects the 128-bit result serially and returns it in parallel with a done pulse.
- Replaces ad-hoc bit-iterator logic in top-level test wrappers; the only owner of both slaves' CS lines.

Parameters:
- DATA_LEN, 128, block width in bits; fixed by AES, not to be overridden.
- KEY_LEN, 192, key width in bits; legal values 128, 192, 256.
- LATENCY, 16, cycles between the last MOSI bit and the first valid MISO bit; must be ≥1.
- CNT_W, 9, counter width; must satisfy 2^CNT_W > DATA_LEN+KEY_LEN and 2^CNT_W > LATENCY.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only when ready=1.
- mode  in  1  0 = encrypt slave, 1 = decrypt slave; sampled with start.
- din  in  DATA_LEN  input block; bit DATA_LEN-1 is sent first.
- key  in  KEY_LEN  key; bit KEY_LEN-1 is sent first, after the block LSB.
- ready  out  1  high only in IDLE.
- busy  out  1  equals !ready.
- done  out  1  one-cycle pulse when dout is valid.
- dout  out  DATA_LEN  result; holds its value until the next done.
- enc_cs  out  1  encrypt slave select, active-low.
- enc_mosi  out  1  serial data to the encrypt slave.
- enc_miso  in  1  serial result from the encrypt slave.
- dec_cs  out  1  decrypt slave select, active-low.
- dec_mosi  out  1  serial data to the decrypt slave.
- dec_miso  in  1  serial result from the decrypt slave.

Behaviour:
- Reset values: state IDLE, ready=1, busy=0, done=0, dout=0, enc_cs=dec_cs=1, enc_mosi=dec_mosi=0, counters 0.
- rst has priority over every other input in any state. A reset mid-transfer deasserts both CS lines at the same edge, drops the transaction and clears dout.
- IDLE: on an edge with start=1:
  - latch shreg={din,key} (DATA_LEN+KEY_LEN bits) and the mode;
  - clear the counter and go to SHIFT_IN.
  - start while busy is ignored, with no queuing.
- SHIFT_IN, DATA_LEN+KEY_LEN cycles:
  - selected cs=0; selected mosi = shreg MSB;
  - shreg shifts left by one each edge; counter increments;
  - at count DATA_LEN+KEY_LEN-1, go to WAIT.
  - The slave samples mosi on posedge while cs=0.
- WAIT, LATENCY cycles: cs stays 0, mosi=0; counter counts LATENCY-1 down to 0, then go to SHIFT_OUT.
- SHIFT_OUT, DATA_LEN cycles:
  - each edge, res <= {res[DATA_LEN-2:0], selected miso}, so the first sampled bit becomes the MSB;
  - cs stays 0; after DATA_LEN samples, go to DONE.
- DONE, 1 cycle: cs=1 for both slaves, dout <= res, done=1, ready=0; next state IDLE.
  - start asserted during DONE is ignored.
  - The earliest next accept is the following cycle.
- Selection and idle levels:
  - The non-selected slave always sees cs=1 and mosi=0.
  - No X is ever driven on any output.
  - Outside transfers, both cs lines are 1.
- Latency: from the start-accept edge to done high = DATA_LEN+KEY_LEN+LATENCY+DATA_LEN+1 cycles; 465 with the defaults.
- The block does not qualify MISO; the slave must present valid bits in SHIFT_OUT.

Decomposition:
- Package aes_ctrl_pkg holds:
  - the state enum {IDLE, SHIFT_IN, WAIT, SHIFT_OUT, DONE};
  - MODE_ENC=0 and MODE_DEC=1;
  - the legal key-length constants 128/192/256 and the FIPS-197 test-vector constants.
- One sub-module, aes_bit_shifter: a parameterised-width shift register with load, shift-out-MSB and shift-in-LSB. It is instantiated twice: TX width DATA_LEN+KEY_LEN, RX width DATA_LEN.

Test Plan:
- Bench uses behavioural slave models with LATENCY=16, KEY_LEN=192.
- Encrypt vector: start, mode=0, din=00112233445566778899aabbccddeeff, key=000102…1617 → done at cycle 465, dout=dda97ca4864cdfe06eaf70a0ec0d7191. dec_cs stays 1 throughout; enc_cs is low for exactly 464 cycles.
- Decrypt round trip: mode=1, din=dda97ca4864cdfe06eaf70a0ec0d7191, same key → dout=00112233445566778899aabbccddeeff. enc_cs stays 1.
- MOSI order: capture enc_mosi during SHIFT_IN → 320-bit stream equals {din,key}, MSB first.
- Busy rejection: pulse start with different data at cycles 10 and 300 of a transfer → no effect, one done only, result unchanged.
- Reset mid-op: assert rst at SHIFT_IN cycle 100 → at the next edge both cs=1, ready=1, dout=0, done never pulses. A new request afterwards completes correctly.
- Back-to-back: hold start=1 continuously → done pulses every 466 cycles, with one IDLE cycle between transactions.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the bit-serial AES host sequencer.
// Also carries the FIPS-197 appendix C vectors used when bringing up the slaves.
package aes_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StShiftIn,
      StWait,
      StShiftOut,
      StDone
   } ctrl_state_e;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   localparam int unsigned KEY_LEN_128 = 128;
   localparam int unsigned KEY_LEN_192 = 192;
   localparam int unsigned KEY_LEN_256 = 256;

   localparam logic [127:0] FIPS_PT      = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_KEY_128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [191:0] FIPS_KEY_192 =
      192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] FIPS_CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [255:0] FIPS_KEY_256 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] FIPS_CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   function automatic logic key_len_legal(input int unsigned len);
      return (len == KEY_LEN_128) || (len == KEY_LEN_192) || (len == KEY_LEN_256);
   endfunction

endpackage

// File: rtl/aes_bit_shifter.sv
// Parallel-load shift register: MSB leaves first, new bits enter at the LSB.
// Load wins over shift when both are requested on the same edge.
module aes_bit_shifter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_i,
   input  logic             bit_i,
   output logic             msb_o,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= load_data_i;
      end else if (shift_i) begin
         data_q <= {data_q[WIDTH-2:0], bit_i};
      end
   end

   assign msb_o  = data_q[WIDTH-1];
   assign data_o = data_q;

endmodule

// File: rtl/aes_serial_ctrl.sv
// Host-side sequencer for the encrypt/decrypt bit-serial AES slaves: shifts {block,key}
// out MSB-first, waits the core latency, collects the 128-bit result and pulses done.
module aes_serial_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int unsigned DATA_LEN = 128,
   parameter int unsigned KEY_LEN  = 192,
   parameter int unsigned LATENCY  = 16,
   parameter int unsigned CNT_W    = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   input  logic [DATA_LEN-1:0] din,
   input  logic [KEY_LEN-1:0]  key,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic [DATA_LEN-1:0] dout,
   output logic                enc_cs,
   output logic                enc_mosi,
   input  logic                enc_miso,
   output logic                dec_cs,
   output logic                dec_mosi,
   input  logic                dec_miso
);

   localparam int unsigned      TxW      = DATA_LEN + KEY_LEN;
   localparam logic [CNT_W-1:0] LastIn   = CNT_W'(TxW - 1);
   localparam logic [CNT_W-1:0] LastOut  = CNT_W'(DATA_LEN - 1);
   localparam logic [CNT_W-1:0] WaitInit = CNT_W'(LATENCY - 1);

   ctrl_state_e         state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                sel_q;
   logic                enc_cs_q;
   logic                dec_cs_q;
   logic                ready_q;
   logic                done_q;
   logic [DATA_LEN-1:0] dout_q;

   logic                accept;
   logic                tx_shift;
   logic                rx_shift;
   logic                rx_bit;
   logic                tx_msb;
   logic [TxW-1:0]      tx_data_unused;
   logic                rx_msb_unused;
   logic [DATA_LEN-1:0] rx_data;

   assign accept   = (state_q == StIdle) && start;
   assign tx_shift = (state_q == StShiftIn);
   assign rx_shift = (state_q == StShiftOut);
   assign rx_bit   = (sel_q == MODE_DEC) ? dec_miso : enc_miso;

   aes_bit_shifter #(
      .WIDTH (TxW)
   ) u_tx (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept),
      .load_data_i ({din, key}),
      .shift_i     (tx_shift),
      .bit_i       (1'b0),
      .msb_o       (tx_msb),
      .data_o      (tx_data_unused)
   );

   // The result register is cleared on accept so a stale result never leaks into dout.
   aes_bit_shifter #(
      .WIDTH (DATA_LEN)
   ) u_rx (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept),
      .load_data_i ('0),
      .shift_i     (rx_shift),
      .bit_i       (rx_bit),
      .msb_o       (rx_msb_unused),
      .data_o      (rx_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sel_q    <= MODE_ENC;
         enc_cs_q <= 1'b1;
         dec_cs_q <= 1'b1;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         dout_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  sel_q    <= mode;
                  cnt_q    <= '0;
                  ready_q  <= 1'b0;
                  enc_cs_q <= (mode != MODE_ENC);
                  dec_cs_q <= (mode != MODE_DEC);
                  state_q  <= StShiftIn;
               end
            end
            StShiftIn: begin
               if (cnt_q == LastIn) begin
                  cnt_q   <= WaitInit;
                  state_q <= StWait;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  state_q <= StShiftOut;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StShiftOut: begin
               if (cnt_q == LastOut) begin
                  cnt_q    <= '0;
                  enc_cs_q <= 1'b1;
                  dec_cs_q <= 1'b1;
                  state_q  <= StDone;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               dout_q  <= rx_data;
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ready    = ready_q;
   assign busy     = ~ready_q;
   assign done     = done_q;
   assign dout     = dout_q;
   assign enc_cs   = enc_cs_q;
   assign dec_cs   = dec_cs_q;
   assign enc_mosi = tx_shift && (sel_q == MODE_ENC) && tx_msb;
   assign dec_mosi = tx_shift && (sel_q == MODE_DEC) && tx_msb;

endmodule
